scc_mem_arbiter: RTL and testbench

Single-port memory arbiter for the scc core. Shares one unified instruction/data memory port between the fetch requester (iFetch side) and the data requester (execute load/store side). Enforces one outstanding read at a time, a fixed memory read latency and a registered read-response path back to each requester.

---
 rtl/scc_mem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_scc_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// scc_mem_arbiter
//   Shares one unified memory port between the fetch requester and the data
//   (load/store) requester. One read may be outstanding at a time; the read
//   data comes back MEM_LAT cycles after issue and is registered into the
//   owner's rdata register with a one-cycle rvalid pulse. Writes finish in
//   the issue cycle.
//
//   Optional feature macro: SCC_ARB_RR_EN
//     defined   : round-robin on simultaneous requests (last_gnt register)
//     undefined : fixed priority, data requester always wins a tie
//
//   Parameters
//     MEM_LAT      memory read latency in cycles, 1..7
//
//   Ports
//     i_clk        core clock, rising edge
//     i_rst_n      asynchronous active-low reset
//     i_if_req     fetch read request, held with i_if_addr until o_if_gnt
//     i_if_addr    fetch byte address
//     o_if_gnt     fetch request accepted this cycle
//     o_if_rvalid  one-cycle pulse, o_if_rdata is new
//     o_if_rdata   last fetch read data
//     i_d_req      data request, held with we/addr/wdata until o_d_gnt
//     i_d_we       1 = write, 0 = read
//     i_d_addr     data byte address
//     i_d_wdata    write data
//     o_d_gnt      data request accepted this cycle
//     o_d_rvalid   one-cycle pulse, o_d_rdata is new (reads only)
//     o_d_rdata    last data read value
//     o_mem_en     memory access strobe, issue cycle only
//     o_mem_we     memory write strobe
//     o_mem_addr   memory address
//     o_mem_wdata  memory write data
//     i_mem_rdata  memory read data, valid MEM_LAT cycles after issue
//     o_busy       read outstanding
//
//   state  | meaning
//   IDLE   | grant allowed, winner issues in the same cycle
//   WAIT   | read outstanding, r_cnt counting down to capture
// ---------------------------------------------------------------------------
module scc_mem_arbiter #(
   parameter int unsigned MEM_LAT = 1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_if_req,
   input  logic [31:0] i_if_addr,
   output logic        o_if_gnt,
   output logic        o_if_rvalid,
   output logic [31:0] o_if_rdata,
   input  logic        i_d_req,
   input  logic        i_d_we,
   input  logic [31:0] i_d_addr,
   input  logic [31:0] i_d_wdata,
   output logic        o_d_gnt,
   output logic        o_d_rvalid,
   output logic [31:0] o_d_rdata,
   output logic        o_mem_en,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   input  logic [31:0] i_mem_rdata,
   output logic        o_busy
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   localparam logic [2:0] CNT_LOAD = 3'(MEM_LAT - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [2:0]  r_cnt;
   logic [2:0]  w_cnt_nxt;
   logic        r_owner_d;
   logic        w_owner_d_nxt;
   logic        w_capture;
   logic        w_pick_d;
   logic        w_if_gnt;
   logic        w_d_gnt;
   logic        r_if_rvalid;
   logic        r_d_rvalid;
   logic [31:0] r_if_rdata;
   logic [31:0] r_d_rdata;

`ifdef SCC_ARB_RR_EN
   // 1 = data requester received the most recent grant
   logic r_last_d;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_last_d <= 1'b0;
      end else if (w_if_gnt || w_d_gnt) begin
         r_last_d <= w_d_gnt;
      end
   end

   // data wins when alone, or on a tie when fetch was granted last
   assign w_pick_d = i_d_req && (!i_if_req || !r_last_d);
`else
   assign w_pick_d = i_d_req;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= 3'd0;
         r_owner_d <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_owner_d <= w_owner_d_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_owner_d_nxt = r_owner_d;
      w_capture     = 1'b0;
      w_if_gnt      = 1'b0;
      w_d_gnt       = 1'b0;
      o_mem_en      = 1'b0;
      o_mem_we      = 1'b0;
      o_mem_addr    = 32'd0;
      o_mem_wdata   = 32'd0;
      case (r_state)
         ST_IDLE: begin
            // i_rst_n term keeps grants and strobes quiet while reset is held
            if (i_rst_n && (i_if_req || i_d_req)) begin
               o_mem_en = 1'b1;
               if (w_pick_d) begin
                  w_d_gnt     = 1'b1;
                  o_mem_we    = i_d_we;
                  o_mem_addr  = i_d_addr;
                  o_mem_wdata = i_d_wdata;
               end else begin
                  w_if_gnt   = 1'b1;
                  o_mem_addr = i_if_addr;
               end
               // writes complete in the issue cycle; only reads wait
               if (!(w_pick_d && i_d_we)) begin
                  w_state_nxt   = ST_WAIT;
                  w_cnt_nxt     = CNT_LOAD;
                  w_owner_d_nxt = w_pick_d;
               end
            end
         end
         ST_WAIT: begin
            if (r_cnt == 3'd0) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 3'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_if_rvalid <= 1'b0;
         r_d_rvalid  <= 1'b0;
         r_if_rdata  <= 32'd0;
         r_d_rdata   <= 32'd0;
      end else begin
         r_if_rvalid <= w_capture && !r_owner_d;
         r_d_rvalid  <= w_capture && r_owner_d;
         if (w_capture && !r_owner_d) begin
            r_if_rdata <= i_mem_rdata;
         end
         if (w_capture && r_owner_d) begin
            r_d_rdata <= i_mem_rdata;
         end
      end
   end

   assign o_if_gnt    = w_if_gnt;
   assign o_d_gnt     = w_d_gnt;
   assign o_if_rvalid = r_if_rvalid;
   assign o_d_rvalid  = r_d_rvalid;
   assign o_if_rdata  = r_if_rdata;
   assign o_d_rdata   = r_d_rdata;
   assign o_busy      = (r_state == ST_WAIT);

endmodule

// File: tb/tb_scc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_scc_mem_arbiter
//   Randomized requesters and memory data against a transaction-level model
//   that tracks the outstanding read by its issue cycle. Occasional resets
//   are dropped in at random points, including mid-read.
// ---------------------------------------------------------------------------
module tb_scc_mem_arbiter;

   localparam int unsigned LAT     = 2;
   localparam int          N_CYC   = 4000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;

   scc_mem_arbiter #(.MEM_LAT(LAT)) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_if_req    (if_req),
      .i_if_addr   (if_addr),
      .o_if_gnt    (if_gnt),
      .o_if_rvalid (if_rvalid),
      .o_if_rdata  (if_rdata),
      .i_d_req     (d_req),
      .i_d_we      (d_we),
      .i_d_addr    (d_addr),
      .i_d_wdata   (d_wdata),
      .o_d_gnt     (d_gnt),
      .o_d_rvalid  (d_rvalid),
      .o_d_rdata   (d_rdata),
      .o_mem_en    (mem_en),
      .o_mem_we    (mem_we),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .i_mem_rdata (mem_rdata),
      .o_busy      (busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // reference model: outstanding read identified by issue cycle and owner
   bit          m_out;
   bit          m_owner_d;
   int          m_issue;
   int          cyc;
   bit          m_if_rv;
   bit          m_d_rv;
   logic [31:0] m_if_rd;
   logic [31:0] m_d_rd;
   bit          m_last_d;

   // requester bookkeeping
   bit          f_gl;
   bit          d_gl;

   task automatic model_reset();
      m_out    = 1'b0;
      m_owner_d = 1'b0;
      m_issue  = 0;
      m_if_rv  = 1'b0;
      m_d_rv   = 1'b0;
      m_if_rd  = 32'd0;
      m_d_rd   = 32'd0;
      m_last_d = 1'b0;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_if_gnt",    32'(if_gnt),    32'd0);
      chk("rst_d_gnt",     32'(d_gnt),     32'd0);
      chk("rst_mem_en",    32'(mem_en),    32'd0);
      chk("rst_mem_we",    32'(mem_we),    32'd0);
      chk("rst_mem_addr",  mem_addr,       32'd0);
      chk("rst_mem_wdata", mem_wdata,      32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
      chk("rst_d_rvalid",  32'(d_rvalid),  32'd0);
      chk("rst_if_rdata",  if_rdata,       32'd0);
      chk("rst_d_rdata",   d_rdata,        32'd0);
   endtask

   initial begin
      bit          e_busy;
      bit          e_if_g;
      bit          e_d_g;
      bit          pick_d;
      bit          e_we;
      logic [31:0] e_addr;

      rst_n     = 1'b0;
      if_req    = 1'b0;
      if_addr   = 32'd0;
      d_req     = 1'b0;
      d_we      = 1'b0;
      d_addr    = 32'd0;
      d_wdata   = 32'd0;
      mem_rdata = 32'd0;
      model_reset();
      cyc  = 0;
      f_gl = 1'b0;
      d_gl = 1'b0;

      repeat (2) @(negedge clk);
      // requests asserted under reset must not be granted
      if_req = 1'b1;
      d_req  = 1'b1;
      #1;
      chk_reset_outputs();
      if_req = 1'b0;
      d_req  = 1'b0;
      rst_n  = 1'b1;

      for (int i = 0; i < N_CYC; i++) begin
         @(negedge clk);

         if (i > 10 && $urandom_range(0, 199) == 0) begin
            rst_n = 1'b0;
            #1;
            chk_reset_outputs();
            model_reset();
            f_gl = 1'b0;
            d_gl = 1'b0;
            @(posedge clk);
            cyc++;
            @(negedge clk);
            rst_n = 1'b1;
         end

         // fetch requester: hold until granted, occasionally withdraw
         if (!(if_req && !f_gl && $urandom_range(0, 19) != 0)) begin
            if_req  = ($urandom_range(0, 2) != 0);
            if_addr = $urandom;
         end
         // data requester: same, one in three is a write
         if (!(d_req && !d_gl && $urandom_range(0, 19) != 0)) begin
            d_req   = ($urandom_range(0, 2) != 0);
            d_we    = ($urandom_range(0, 2) == 0);
            d_addr  = $urandom;
            d_wdata = $urandom;
         end
         mem_rdata = $urandom;
         #1;

         e_busy = m_out;
         e_if_g = 1'b0;
         e_d_g  = 1'b0;
         pick_d = 1'b0;
         if (!e_busy && (if_req || d_req)) begin
            if (if_req && d_req) begin
`ifdef SCC_ARB_RR_EN
               pick_d = !m_last_d;
`else
               pick_d = 1'b1;
`endif
            end else begin
               pick_d = d_req;
            end
            e_d_g  = pick_d;
            e_if_g = !pick_d;
         end
         e_we   = e_d_g && d_we;
         e_addr = e_d_g ? d_addr : (e_if_g ? if_addr : 32'd0);

         chk("busy",      32'(busy),      32'(e_busy));
         chk("if_gnt",    32'(if_gnt),    32'(e_if_g));
         chk("d_gnt",     32'(d_gnt),     32'(e_d_g));
         chk("mem_en",    32'(mem_en),    32'(e_if_g || e_d_g));
         chk("if_rvalid", 32'(if_rvalid), 32'(m_if_rv));
         chk("d_rvalid",  32'(d_rvalid),  32'(m_d_rv));
         chk("if_rdata",  if_rdata,       m_if_rd);
         chk("d_rdata",   d_rdata,        m_d_rd);
         if (!e_busy) begin
            chk("mem_we",   32'(mem_we), 32'(e_we));
            chk("mem_addr", mem_addr,    e_addr);
            if (e_d_g) begin
               chk("mem_wdata", mem_wdata, d_wdata);
            end else if (!e_if_g) begin
               chk("mem_wdata_idle", mem_wdata, 32'd0);
            end
         end

         @(posedge clk);
         m_if_rv = 1'b0;
         m_d_rv  = 1'b0;
         if (m_out && cyc == m_issue + int'(LAT)) begin
            m_out = 1'b0;
            if (m_owner_d) begin
               m_d_rd = mem_rdata;
               m_d_rv = 1'b1;
            end else begin
               m_if_rd = mem_rdata;
               m_if_rv = 1'b1;
            end
         end
         if (e_if_g || e_d_g) begin
            m_last_d = e_d_g;
            if (!e_we) begin
               m_out     = 1'b1;
               m_owner_d = e_d_g;
               m_issue   = cyc;
            end
         end
         f_gl = e_if_g;
         d_gl = e_d_g;
         cyc++;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
